// File: rtl/or1200_wb_arb_pkg.sv
// or1200_wb_arb_pkg
//   Shared definitions for the two-master Wishbone arbiter:
//   arbitration state encoding, Wishbone cycle-type constants and the
//   tie-break helper used when leaving IDLE.
package or1200_wb_arb_pkg;

  // Arbitration state: which master (if any) currently owns the slave port
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  // Wishbone B3 cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Grant decision out of IDLE. On a tie the master that did not own
  // the bus last wins, which gives round-robin fairness between the two.
  function automatic arb_state_t idleGrant(input logic c0,
                                           input logic c1,
                                           input logic lastGnt);
    arb_state_t nxt;
    nxt = IDLE;
    if (c0 && c1)
      nxt = lastGnt ? GNT0 : GNT1;
    else if (c0)
      nxt = GNT0;
    else if (c1)
      nxt = GNT1;
    return nxt;
  endfunction

endpackage

// File: rtl/or1200_wb_arb_wdog.sv
// or1200_wb_arb_wdog
//   Bus watchdog for the arbiter. Counts consecutive cycles in which the
//   granted master is strobing and the slave answers with neither ack nor
//   err. When the count reaches WD_CYCLES it raises o_timeout for one
//   cycle; the arbiter turns that into an error to the granted master.
//   Only instantiated when OR1200_WB_ARB_WATCHDOG_EN is defined.
//
// Ports
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-low reset
//   i_active  : a master is currently granted
//   i_stb     : strobe of the granted master
//   i_ack     : slave ack
//   i_err     : slave error
//   o_timeout : one-cycle pulse when the limit is reached
module or1200_wb_arb_wdog #(
  parameter int WD_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_err,
  output logic o_timeout
);

  localparam int CW = $clog2(WD_CYCLES + 1);

  logic [CW-1:0] r_count;
  // Sticky indication that a timeout has ever fired since reset
  logic          r_wdFlag;

  assign o_timeout = i_active && (r_count == CW'(WD_CYCLES));

  // Stall counter: any response, a dropped strobe or an idle bus restarts
  // the count; a timeout also restarts it so the next hang is timed afresh.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_count  <= '0;
      r_wdFlag <= 1'b0;
    end else if (o_timeout) begin
      r_count  <= '0;
      r_wdFlag <= 1'b1;
    end else if (!i_active || !i_stb || i_ack || i_err) begin
      r_count  <= '0;
    end else begin
      r_count  <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/or1200_wb_arb.sv
// or1200_wb_arb
//   Two-master, one-slave Wishbone B3 arbiter between the OR1200
//   instruction bus (master 0) and data bus (master 1). The grant is
//   registered and round-robin on ties; once granted, a master keeps the
//   bus for as long as it holds cyc (bursts and stb gaps included). The
//   slave side is a combinational mux of the granted master, so the slave
//   cycle starts one clock after the request.
//
//   Optional feature macro: OR1200_WB_ARB_WATCHDOG_EN
//     Adds a bus watchdog that errors out a cycle left without ack/err
//     for WD_CYCLES strobing cycles.
//
// Ports
//   clk_i, rst_i            : clock, synchronous active-low reset
//   m0_* / m1_*             : Wishbone master interfaces (iwb, dwb)
//     *_cyc_i,_stb_i,_we_i  : cycle, strobe, write enable
//     *_adr_i,_sel_i,_dat_i : address, byte selects, write data
//     *_cti_i               : cycle type
//     *_dat_o,_ack_o,_err_o : read data, ack, error back to the master
//   s_*                     : Wishbone slave interface
module or1200_wb_arb
  import or1200_wb_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int WD_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // master 0 (instruction bus)
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [2:0]      m0_cti_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1 (data bus)
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [2:0]      m1_cti_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // slave
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [2:0]      s_cti_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);

  arb_state_t r_state;
  // Owner of the most recently completed grant (0 = m0, 1 = m1)
  logic       r_lastGnt;
  logic       w_wdTimeout;

  // Arbitration FSM. Leaving a grant hands the bus straight to a waiting
  // master without an IDLE cycle; a master that drops and immediately
  // re-raises cyc therefore queues behind the other one.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_lastGnt <= 1'b1;
    end else begin
      case (r_state)
        IDLE: r_state <= idleGrant(m0_cyc_i, m1_cyc_i, r_lastGnt);
        GNT0: begin
          if (!m0_cyc_i) begin
            r_lastGnt <= 1'b0;
            r_state   <= m1_cyc_i ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            r_lastGnt <= 1'b1;
            r_state   <= m0_cyc_i ? GNT0 : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus routing. The granted master drives the slave directly and sees the
  // slave response; the other master and an idle bus see all zeros. A
  // watchdog timeout kills cyc/stb and reports an error in the same cycle.
  always_ff @(posedge clk_i) begin end
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    s_cti_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~w_wdTimeout;
        s_stb_o  = m0_stb_i & ~w_wdTimeout;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        s_cti_o  = m0_cti_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | w_wdTimeout;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~w_wdTimeout;
        s_stb_o  = m1_stb_i & ~w_wdTimeout;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        s_cti_o  = m1_cti_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | w_wdTimeout;
      end
      default: ;
    endcase
  end

`ifdef OR1200_WB_ARB_WATCHDOG_EN
  logic w_active;
  logic w_grantStb;

  // The watchdog watches the raw master strobe, not s_stb_o, so that its
  // own forcing of s_stb_o cannot feed back into the count.
  assign w_active   = (r_state != IDLE);
  assign w_grantStb = (r_state == GNT0) ? m0_stb_i :
                      (r_state == GNT1) ? m1_stb_i : 1'b0;

  or1200_wb_arb_wdog #(
    .WD_CYCLES (WD_CYCLES)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_active  (w_active),
    .i_stb     (w_grantStb),
    .i_ack     (s_ack_i),
    .i_err     (s_err_i),
    .o_timeout (w_wdTimeout)
  );
`else
  // No watchdog in this build: errors come from the slave only and
  // WD_CYCLES has no effect.
  assign w_wdTimeout = (WD_CYCLES < 0);
`endif

endmodule

// File: tb/tb_or1200_wb_arb.sv
// tb_or1200_wb_arb
//   Directed, table-driven bench for or1200_wb_arb. Each table row is one
//   clock cycle: the inputs applied in that cycle and the outputs expected
//   while they are applied. Hand-written sequences cover reset, grant
//   latency and (when OR1200_WB_ARB_WATCHDOG_EN is defined) the watchdog.
module tb_or1200_wb_arb;
  import or1200_wb_arb_pkg::*;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] M0D = 32'h1111_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [2:0]  m0_cti_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [2:0]  m1_cti_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rstN;
    logic        c0, s0;
    logic [31:0] a0;
    logic        c1, s1, w1;
    logic [31:0] a1;
    logic [3:0]  sel1;
    logic [31:0] d1;
    logic [2:0]  cti1;
    logic [31:0] sdat;
    logic        sack, serr;
    logic [159:0] expOut;
  } vec_t;

  vec_t vecs[$];

  or1200_wb_arb #(
    .AW(32), .DW(32), .WD_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_cti_i(m0_cti_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_cti_i(m1_cti_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_cti_o(s_cti_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Safety net so the run always ends even if the DUT wedges the bench
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "[TB] global time limit reached");
  end

  function automatic logic [159:0] packOut(
    input logic scyc, input logic sstb, input logic swe,
    input logic [31:0] sadr, input logic [3:0] ssel, input logic [31:0] sdo,
    input logic [2:0] scti,
    input logic a0, input logic e0, input logic [31:0] d0,
    input logic a1, input logic e1, input logic [31:0] d1);
    return {18'h0, scyc, sstb, swe, sadr, ssel, sdo, scti, a0, e0, d0, a1, e1, d1};
  endfunction

  function automatic logic [159:0] dutOut();
    return packOut(s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o,
                   m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o);
  endfunction

  task automatic addVec(
    input logic rstN, input logic c0, input logic s0, input logic [31:0] a0,
    input logic c1, input logic s1, input logic w1, input logic [31:0] a1,
    input logic [3:0] sel1, input logic [31:0] d1, input logic [2:0] cti1,
    input logic [31:0] sdat, input logic sack, input logic serr,
    input logic escyc, input logic estb, input logic ewe, input logic [31:0] eadr,
    input logic [3:0] esel, input logic [31:0] edo, input logic [2:0] ecti,
    input logic ea0, input logic ee0, input logic [31:0] ed0,
    input logic ea1, input logic ee1, input logic [31:0] ed1);
    vec_t v;
    v.rstN = rstN; v.c0 = c0; v.s0 = s0; v.a0 = a0;
    v.c1 = c1; v.s1 = s1; v.w1 = w1; v.a1 = a1; v.sel1 = sel1; v.d1 = d1;
    v.cti1 = cti1; v.sdat = sdat; v.sack = sack; v.serr = serr;
    v.expOut = packOut(escyc, estb, ewe, eadr, esel, edo, ecti,
                       ea0, ee0, ed0, ea1, ee1, ed1);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_i    = v.rstN;
    m0_cyc_i = v.c0;  m0_stb_i = v.s0; m0_we_i = 1'b0; m0_adr_i = v.a0;
    m0_sel_i = 4'hF;  m0_dat_i = M0D;  m0_cti_i = CTI_CLASSIC;
    m1_cyc_i = v.c1;  m1_stb_i = v.s1; m1_we_i = v.w1; m1_adr_i = v.a1;
    m1_sel_i = v.sel1; m1_dat_i = v.d1; m1_cti_i = v.cti1;
    s_dat_i  = v.sdat; s_ack_i = v.sack; s_err_i = v.serr;
  endtask

  task automatic checkOutput(input string name, input logic [159:0] act,
                             input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    vec_t v;
    v = '{rstN: rst_i, c0: N, s0: N, a0: 32'h0, c1: N, s1: N, w1: N, a1: 32'h0,
          sel1: 4'h0, d1: 32'h0, cti1: CTI_CLASSIC, sdat: 32'h0, sack: N, serr: N,
          expOut: '0};
    applyStimulus(v);
  endtask

  initial begin
    int cycles;
    rst_i = 1'b0;
    idleInputs();

    // rstN  m0:cyc stb adr    m1:cyc stb we adr sel dat cti   slave:dat ack err
    //   expected: s cyc stb we adr sel dat cti | m0 ack err dat | m1 ack err dat
    addVec(Y, Y,Y,32'h100, N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, 32'h55,Y,N,
           N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, Y,Y,32'h100, N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, 32'h0,N,N,
           Y,Y,N,32'h100,4'hF,M0D,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, Y,Y,32'h100, N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, 32'hCAFE0001,Y,N,
           Y,Y,N,32'h100,4'hF,M0D,CTI_CLASSIC, Y,N,32'hCAFE0001, N,N,32'h0);
    addVec(Y, N,N,32'h100, N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h100,4'hF,M0D,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    // reset with both requesting, then tie goes to m0
    addVec(N, Y,Y,32'h200, Y,Y,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, Y,Y,32'h200, Y,Y,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, Y,Y,32'h200, Y,Y,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'hA7,Y,N,
           Y,Y,N,32'h200,4'hF,M0D,CTI_CLASSIC, Y,N,32'hA7, N,N,32'h0);
    addVec(Y, N,N,32'h200, Y,Y,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h200,4'hF,M0D,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    // m1 granted with no idle gap; m0 re-raised cyc and must wait
    addVec(Y, Y,Y,32'h200, Y,Y,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'hB9,Y,N,
           Y,Y,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, N,N,32'h0, Y,N,32'hB9);
    addVec(Y, Y,Y,32'h200, N,N,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, N,N,32'h200, N,N,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h200,4'hF,M0D,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    // tie after m0 was last served goes to m1; m1 runs an INCR burst
    addVec(Y, Y,Y,32'h200, Y,Y,N,32'h300,4'hC,32'h2222,CTI_INCR, 32'h0,N,N,
           N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, Y,Y,32'h200, Y,Y,N,32'h300,4'hC,32'h2222,CTI_INCR, 32'hD0,Y,N,
           Y,Y,N,32'h300,4'hC,32'h2222,CTI_INCR, N,N,32'h0, Y,N,32'hD0);
    addVec(Y, Y,Y,32'h200, Y,Y,N,32'h304,4'hC,32'h2222,CTI_INCR, 32'hD1,Y,N,
           Y,Y,N,32'h304,4'hC,32'h2222,CTI_INCR, N,N,32'h0, Y,N,32'hD1);
    addVec(Y, Y,Y,32'h200, Y,N,N,32'h308,4'hC,32'h2222,CTI_INCR, 32'h0,N,N,
           Y,N,N,32'h308,4'hC,32'h2222,CTI_INCR, N,N,32'h0, N,N,32'h0);
    addVec(Y, Y,Y,32'h200, Y,Y,N,32'h308,4'hC,32'h2222,CTI_INCR, 32'hD2,Y,N,
           Y,Y,N,32'h308,4'hC,32'h2222,CTI_INCR, N,N,32'h0, Y,N,32'hD2);
    addVec(Y, Y,Y,32'h200, Y,Y,N,32'h30C,4'hC,32'h2222,CTI_EOB, 32'hD3,Y,N,
           Y,Y,N,32'h30C,4'hC,32'h2222,CTI_EOB, N,N,32'h0, Y,N,32'hD3);
    addVec(Y, Y,Y,32'h200, N,N,N,32'h30C,4'hC,32'h2222,CTI_EOB, 32'h0,N,N,
           N,N,N,32'h30C,4'hC,32'h2222,CTI_EOB, N,N,32'h0, N,N,32'h0);
    // m0 granted as m1 releases; m1 queues a write
    addVec(Y, Y,Y,32'h200, Y,Y,Y,32'h400,4'h3,32'hDEADBEEF,CTI_CLASSIC, 32'hE0,Y,N,
           Y,Y,N,32'h200,4'hF,M0D,CTI_CLASSIC, Y,N,32'hE0, N,N,32'h0);
    addVec(Y, N,N,32'h200, Y,Y,Y,32'h400,4'h3,32'hDEADBEEF,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h200,4'hF,M0D,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, N,N,32'h200, Y,Y,Y,32'h400,4'h3,32'hDEADBEEF,CTI_CLASSIC, 32'h0,N,Y,
           Y,Y,Y,32'h400,4'h3,32'hDEADBEEF,CTI_CLASSIC, N,N,32'h0, N,Y,32'h0);
    addVec(Y, N,N,32'h200, N,N,N,32'h400,4'h3,32'hDEADBEEF,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h400,4'h3,32'hDEADBEEF,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    // reset in the middle of an m0 transfer
    addVec(Y, Y,Y,32'h100, N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, 32'h0,N,N,
           N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(N, Y,Y,32'h100, N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, 32'h0,N,N,
           Y,Y,N,32'h100,4'hF,M0D,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, Y,Y,32'h100, Y,Y,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'hF0,Y,N,
           N,N,N,32'h0,4'h0,32'h0,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);
    addVec(Y, Y,Y,32'h100, Y,Y,N,32'h300,4'hC,32'h2222,CTI_CLASSIC, 32'h0,N,N,
           Y,Y,N,32'h100,4'hF,M0D,CTI_CLASSIC, N,N,32'h0, N,N,32'h0);

    // Reset with both masters requesting and the slave acking: bus stays quiet
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset", dutOut(), '0);

    // Grant latency: s_cyc_o must follow a lone request after one clock
    idleInputs();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100;
    cycles = 0;
    while (!s_cyc_o && cycles < 8) begin
      @(posedge clk_i); #1;
      cycles++;
    end
    checkOutput("grantLatency", 160'(cycles), 160'(1));
    idleInputs();
    @(posedge clk_i); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk_i);
      checkOutput($sformatf("row%0d", i + 1), dutOut(), vecs[i].expOut);
      @(posedge clk_i); #1;
    end

`ifdef OR1200_WB_ARB_WATCHDOG_EN
    begin
      int errAt;
      logic stbAtErr, cycAtErr;
      rst_i = 1'b0;
      idleInputs();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h500;
      @(posedge clk_i); #1;
      errAt = -1; stbAtErr = 1'b1; cycAtErr = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk_i);
        if (m0_err_o) begin
          errAt = i; stbAtErr = s_stb_o; cycAtErr = s_cyc_o;
          break;
        end
        @(posedge clk_i); #1;
      end
      checkOutput("wdogErrCycle", 160'(errAt), 160'(8));
      checkOutput("wdogBusForcedLow", {158'h0, cycAtErr, stbAtErr}, '0);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h600;
      @(posedge clk_i); #1;
      checkOutput("wdogRelease", {126'h0, s_cyc_o, s_adr_o, m0_err_o},
                  {126'h0, 1'b1, 32'h600, 1'b0});
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
